mem: RTL and testbench

//   Single-port synchronous word memory (256 x 32 by default) shared over a

---
 rtl/mem.sv | 58 +++++
 tb/tb_mem.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem.sv
// mem -- single-port synchronous word memory on a shared tri-state bus.
//
// This is the near-memory storage block of the CNN accelerator. It holds
// weights and activations for the compute units. Every access is qualified
// by a chip select and a write enable.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; clears the whole array and
//                the read register
//   sel          chip select; 0 = idle, with the bus released
//   w_en         1 = write cycle, 0 = read cycle (only meaningful with sel=1)
//   address_bus  word address, ADDR_WIDTH bits; every value is a valid word
//   data_bus     bidirectional data. It carries write data in, and read data
//                out when this block owns the bus.
module mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] address_bus,
  inout  wire  [DATA_WIDTH-1:0] data_bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_array [DEPTH];
  logic [DATA_WIDTH-1:0] rdata;
  logic                  drive_en;

  // Reset clears every word as well as the read register. The array is
  // therefore built from resettable flops rather than a RAM macro. A write
  // that is cut short by reset is lost along with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_array[i] <= '0;
      end
      rdata <= '0;
    end else if (sel) begin
      if (w_en) begin
        mem_array[address_bus] <= data_bus;
      end else begin
        rdata <= mem_array[address_bus];
      end
    end
  end

  // The bus enable is purely combinational. The block lets go of the bus
  // as soon as reset asserts, sel drops, or a write cycle begins. It does
  // not wait for a clock edge to do this.
  assign drive_en = rst_n & sel & ~w_en;
  assign data_bus = drive_en ? rdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem.sv
// tb_mem -- self-checking bench for mem (256 x 32).
//
// Inputs change just after the falling edge. Outputs are sampled 1 ns after
// the rising edge. A plain array holds the expected memory contents and is
// updated by the memory rules: reset zeroes all of it, and a write stores
// the word.
module tb_mem;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  logic                  clk;
  logic                  rst_n;
  logic                  sel;
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] address_bus;
  logic                  tb_drive;
  logic [DATA_WIDTH-1:0] tb_data;
  wire  [DATA_WIDTH-1:0] data_bus;

  logic [DATA_WIDTH-1:0] model [DEPTH];
  logic [DATA_WIDTH-1:0] exp_rdata;
  logic [DATA_WIDTH-1:0] sweep_words [DEPTH];

  int n_checks;
  int n_fails;

  assign data_bus = tb_drive ? tb_data : {DATA_WIDTH{1'bz}};

  mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel        (sel),
    .w_en       (w_en),
    .address_bus(address_bus),
    .data_bus   (data_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overall time limit, so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: timeout reached, observed=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  // Compares a bus value against its expected value.
  task automatic check_output(input string tag, input logic [DATA_WIDTH-1:0] obs,
                              input logic [DATA_WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks that the bus is not driven by the DUT while the bench has also
  // released it. Depending on the simulator, an undriven bus reads either
  // as Z or as 0.
  task automatic check_released(input string tag);
    logic released;
    released = (data_bus === {DATA_WIDTH{1'bz}}) || (data_bus === {DATA_WIDTH{1'b0}});
    n_checks++;
    assert (released === 1'b1) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed=%h expected=released(Z)", tag, data_bus);
    end
  endtask

  // Drives one bus cycle after the falling edge, then waits for the
  // rising edge plus 1 ns.
  task automatic apply_stimulus(input logic s, input logic we,
                                input logic [ADDR_WIDTH-1:0] a,
                                input logic drv, input logic [DATA_WIDTH-1:0] d);
    @(negedge clk);
    sel         = s;
    w_en        = we;
    address_bus = a;
    tb_drive    = drv;
    tb_data     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp_rdata = '0;
  endtask

  task automatic do_write(input logic [ADDR_WIDTH-1:0] a,
                          input logic [DATA_WIDTH-1:0] d, input string tag);
    apply_stimulus(1'b1, 1'b1, a, 1'b1, d);
    model[a] = d;
    check_output(tag, data_bus, d);
  endtask

  task automatic do_read(input logic [ADDR_WIDTH-1:0] a, input string tag);
    apply_stimulus(1'b1, 1'b0, a, 1'b0, '0);
    exp_rdata = model[a];
    check_output(tag, data_bus, exp_rdata);
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    rst_n       = 1'b1;
    sel         = 1'b0;
    w_en        = 1'b0;
    address_bus = '0;
    tb_drive    = 1'b0;
    tb_data     = '0;

    // Reset pulse; the bus must be released while reset is held.
    #3;
    rst_n = 1'b0;
    #4;
    check_released("reset_bus_z");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    do_read(8'h00, "reset_read_00");
    do_read(8'hFF, "reset_read_ff");

    // Full sweep: random words written to every address, one per cycle.
    for (int i = 0; i < DEPTH; i++) begin
      sweep_words[i] = $urandom;
      do_write(i[ADDR_WIDTH-1:0], sweep_words[i], "sweep_write_bus");
    end
    // Each read is held for two cycles; the word must be stable.
    for (int i = 0; i < DEPTH; i++) begin
      do_read(i[ADDR_WIDTH-1:0], "sweep_read_c1");
      do_read(i[ADDR_WIDTH-1:0], "sweep_read_c2");
      check_output("sweep_vs_written", data_bus, sweep_words[i]);
    end

    // Bus ownership: put a known nonzero word in the read register first.
    do_write(8'h30, 32'h1234_5678, "own_setup_write");
    do_read(8'h30, "own_setup_read");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, i[0], ADDR_WIDTH'($urandom), 1'b0, '0);
      check_released("own_desel_released");
    end
    apply_stimulus(1'b0, 1'b1, 8'h30, 1'b1, 32'hCAFE_F00D);
    check_output("own_desel_tb_value", data_bus, 32'hCAFE_F00D);
    do_read(8'h30, "own_desel_no_write");

    // Latency: the old word is still on the bus before the edge, and the
    // new word appears after exactly one edge.
    do_write(8'h10, 32'hDEAD_BEEF, "lat_write");
    @(negedge clk);
    sel         = 1'b1;
    w_en        = 1'b0;
    address_bus = 8'h10;
    tb_drive    = 1'b0;
    #1;
    check_output("lat_before_edge", data_bus, exp_rdata);
    @(posedge clk);
    #1;
    exp_rdata = model[8'h10];
    check_output("lat_after_edge", data_bus, 32'hDEAD_BEEF);

    // Back-to-back write followed by read, then an overwrite.
    do_write(8'h20, 32'hA5A5_A5A5, "b2b_write1");
    do_read(8'h20, "b2b_read1");
    do_write(8'h20, 32'h5A5A_5A5A, "b2b_write2");
    do_read(8'h20, "b2b_read2");

    // Random mixed traffic against the model.
    for (int i = 0; i < 200; i++) begin
      logic [ADDR_WIDTH-1:0] a;
      a = ADDR_WIDTH'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0: do_write(a, $urandom, "rand_write_bus");
        1: do_read(a, "rand_read");
        default: begin
          apply_stimulus(1'b0, 1'($urandom), a, 1'b0, '0);
          check_released("rand_desel_released");
        end
      endcase
    end

    // Async reset in the middle of a read; nonzero word on the bus first.
    do_read(8'h30, "arst_setup_read");
    #3;
    rst_n = 1'b0;
    #1;
    check_released("arst_bus_z");
    model_reset();
    #2;
    rst_n = 1'b1;
    do_read(ADDR_WIDTH'($urandom), "arst_read_rand");
    do_read(8'h30, "arst_read_30");
    do_read(8'h10, "arst_read_10");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
